// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the masked register RAM.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic int unsigned sram_width(input int unsigned lane_width,
                                             input int unsigned num_lane);
    return lane_width * num_lane;
  endfunction

  // Only 1- and 2-cycle read pipelines are implemented.
  function automatic bit read_lat_legal(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_mask_lane.sv
// One lane of the masked RAM: a DEPTH x LANE_WIDTH register array with
// synchronous write and combinational read.
module ram_mask_lane #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LANE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LANE_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [LANE_WIDTH-1:0] rdata_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LANE_WIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; the top gates out-of-range writes.
  always_ff @(posedge clk) begin
    if (we) mem_q[IDX_W'(waddr)] <= wdata;
  end

  assign rdata_c = mem_q[IDX_W'(raddr)];

endmodule

// File: rtl/ram_reg_mask.sv
// Masked 1R1W register RAM with 1/2-cycle read latency and a zero-fill engine.
// Define RAM_REG_MASK_FWD_EN for write-first forwarding on same-address collisions.
module ram_reg_mask
  import ram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned SRAM_DEPTH      = 2**SRAM_ADDR_WIDTH,
  parameter int unsigned LANE_WIDTH      = 8,
  parameter int unsigned NUM_LANE        = 8,
  localparam int unsigned SRAM_WIDTH     = sram_width(LANE_WIDTH, NUM_LANE),
  parameter int unsigned READ_LAT        = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  output logic                       busy,
  input  logic                       read_en,
  input  logic [SRAM_ADDR_WIDTH-1:0] addr_r,
  input  logic                       write_en,
  input  logic [SRAM_ADDR_WIDTH-1:0] addr_w,
  input  logic [NUM_LANE-1:0]        wmask,
  input  logic [SRAM_WIDTH-1:0]      data_in,
  output logic [SRAM_WIDTH-1:0]      data_out,
  output logic                       data_out_vld
);

  localparam int unsigned AW          = SRAM_ADDR_WIDTH;
  localparam int unsigned LW          = LANE_WIDTH;
  localparam bit          READ_LAT_OK = read_lat_legal(READ_LAT);
  localparam bit          LAT2        = READ_LAT_OK && (READ_LAT == 2);

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic [SRAM_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [SRAM_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_out_vld_q, data_out_vld_d;

  logic                  rd_acc_c, wr_acc_c;
  logic                  rd_in_range_c, wr_in_range_c;
  logic [NUM_LANE-1:0]   lane_we_c;
  logic [AW-1:0]         lane_waddr_c;
  logic [SRAM_WIDTH-1:0] lane_wdata_c;
  logic [SRAM_WIDTH-1:0] rd_raw_c;
  logic [SRAM_WIDTH-1:0] rd_word_c;

  assign rd_in_range_c = {1'b0, addr_r} < (AW+1)'(SRAM_DEPTH);
  assign wr_in_range_c = {1'b0, addr_w} < (AW+1)'(SRAM_DEPTH);
  assign rd_acc_c      = read_en & ~busy_q;
  assign wr_acc_c      = write_en & ~busy_q & wr_in_range_c;

  // The clear engine takes over the write port of every lane while busy.
  assign lane_waddr_c = busy_q ? clr_cnt_q : addr_w;
  assign lane_wdata_c = busy_q ? '0 : data_in;

  for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
    assign lane_we_c[i] = busy_q | (wr_acc_c & wmask[i]);

    ram_mask_lane #(
      .ADDR_WIDTH (AW),
      .DEPTH      (SRAM_DEPTH),
      .LANE_WIDTH (LW)
    ) u_lane (
      .clk     (clk),
      .we      (lane_we_c[i]),
      .waddr   (lane_waddr_c),
      .wdata   (lane_wdata_c[i*LW +: LW]),
      .raddr   (addr_r),
      .rdata_c (rd_raw_c[i*LW +: LW])
    );
  end

  // Read word: zero when out of range, optionally merged with a colliding write.
  always_comb begin
    rd_word_c = '0;
    if (rd_in_range_c) begin
      rd_word_c = rd_raw_c;
`ifdef RAM_REG_MASK_FWD_EN
      if (wr_acc_c && (addr_w == addr_r)) begin
        for (int i = 0; i < NUM_LANE; i++) begin
          if (wmask[i]) rd_word_c[i*LW +: LW] = data_in[i*LW +: LW];
        end
      end
`endif
    end
  end

  // Clear FSM: one word per cycle from address 0 up to SRAM_DEPTH-1.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == AW'(SRAM_DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          busy_d    = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Read pipeline; data registers hold their value between completed reads.
  always_comb begin
    s1_vld_d  = rd_acc_c;
    s1_data_d = rd_acc_c ? rd_word_c : s1_data_q;
    if (LAT2) begin
      data_out_vld_d = s1_vld_q;
      data_out_d     = s1_vld_q ? s1_data_q : data_out_q;
    end else begin
      data_out_vld_d = rd_acc_c;
      data_out_d     = rd_acc_c ? rd_word_c : data_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      clr_cnt_q      <= '0;
      busy_q         <= 1'b0;
      s1_data_q      <= '0;
      s1_vld_q       <= 1'b0;
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      busy_q         <= busy_d;
      s1_data_q      <= s1_data_d;
      s1_vld_q       <= s1_vld_d;
      data_out_q     <= data_out_d;
      data_out_vld_q <= data_out_vld_d;
    end
  end

  assign busy         = busy_q;
  assign data_out     = data_out_q;
  assign data_out_vld = data_out_vld_q;

endmodule

// File: tb/tb_ram_reg_mask.sv
// Bench for ram_reg_mask: a 1024-deep READ_LAT=1 instance and a 1000-deep READ_LAT=2 instance.
module tb_ram_reg_mask;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        read_en;
  logic [9:0]  addr_r;
  logic        write_en;
  logic [9:0]  addr_w;
  logic [7:0]  wmask;
  logic [63:0] data_in;

  logic        d0_busy, d0_vld, d1_busy, d1_vld;
  logic [63:0] d0_data, d1_data;

  ram_reg_mask u_dut0 (
    .clk (clk), .rst_n (rst_n), .clear (clear), .busy (d0_busy),
    .read_en (read_en), .addr_r (addr_r), .write_en (write_en), .addr_w (addr_w),
    .wmask (wmask), .data_in (data_in), .data_out (d0_data), .data_out_vld (d0_vld)
  );

  ram_reg_mask #(.SRAM_DEPTH(1000), .READ_LAT(2)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .clear (clear), .busy (d1_busy),
    .read_en (read_en), .addr_r (addr_r), .write_en (write_en), .addr_w (addr_w),
    .wmask (wmask), .data_in (data_in), .data_out (d1_data), .data_out_vld (d1_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned ntotal = 0;
  int unsigned npass  = 0;

  // Reference model: word arrays, per-lane "known" flags, clear words remaining.
  logic [63:0] mmem   [2][1024];
  logic [7:0]  mknown [2][1024];
  int unsigned rem    [2];
  bit          ebusy  [2];
  bit          ev     [2];
  logic [63:0] ed     [2];
  logic [7:0]  ek     [2];
  bit          pv;
  logic [63:0] pd;
  logic [7:0]  pk;

  typedef struct {
    bit          clr;
    bit          re;
    logic [9:0]  ar;
    bit          we;
    logic [9:0]  aw;
    logic [7:0]  wm;
    logic [63:0] din;
    bit          ev;
    logic [63:0] ed;
  } vec_t;

  vec_t tv [14];

  function automatic vec_t mk(bit re, logic [9:0] ar, bit we, logic [9:0] aw,
                              logic [7:0] wm, logic [63:0] din, bit xv, logic [63:0] xd);
    vec_t v;
    v.clr = 1'b0; v.re = re; v.ar = ar; v.we = we; v.aw = aw;
    v.wm = wm; v.din = din; v.ev = xv; v.ed = xd;
    return v;
  endfunction

  function automatic logic [63:0] lane_mask(logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int l = 0; l < 8; l++) if (k[l]) m[l*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; ebusy[k] = 1'b0; ev[k] = 1'b0; ed[k] = '0; ek[k] = 8'hFF;
    end
    pv = 1'b0; pd = '0; pk = 8'hFF;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit          rv;
      logic [63:0] rd;
      logic [7:0]  rk;
      int unsigned d;
      d  = (k == 0) ? 1024 : 1000;
      rv = 1'b0; rd = '0; rk = 8'hFF;
      if (rem[k] > 0) begin
        mmem[k][d - rem[k]]   = '0;
        mknown[k][d - rem[k]] = 8'hFF;
        rem[k]--;
      end else begin
        if (read_en) begin
          rv = 1'b1;
          if (int'(addr_r) < int'(d)) begin
            rd = mmem[k][addr_r];
            rk = mknown[k][addr_r];
`ifdef RAM_REG_MASK_FWD_EN
            if (write_en && addr_w == addr_r)
              for (int l = 0; l < 8; l++)
                if (wmask[l]) begin rd[l*8 +: 8] = data_in[l*8 +: 8]; rk[l] = 1'b1; end
`endif
          end
        end
        if (write_en && int'(addr_w) < int'(d))
          for (int l = 0; l < 8; l++)
            if (wmask[l]) begin
              mmem[k][addr_w][l*8 +: 8] = data_in[l*8 +: 8];
              mknown[k][addr_w][l] = 1'b1;
            end
        if (clear) rem[k] = d;
      end
      ebusy[k] = rem[k] > 0;
      if (k == 0) begin
        ev[k] = rv;
        if (rv) begin ed[k] = rd; ek[k] = rk; end
      end else begin
        ev[k] = pv;
        if (pv) begin ed[k] = pd; ek[k] = pk; end
        pv = rv;
        if (rv) begin pd = rd; pk = rk; end
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] m;
    m = lane_mask(ek[0]);
    chk("d0_busy", 64'(d0_busy), 64'(ebusy[0]));
    chk("d0_vld",  64'(d0_vld),  64'(ev[0]));
    chk("d0_data", d0_data & m,  ed[0] & m);
    m = lane_mask(ek[1]);
    chk("d1_busy", 64'(d1_busy), 64'(ebusy[1]));
    chk("d1_vld",  64'(d1_vld),  64'(ev[1]));
    chk("d1_data", d1_data & m,  ed[1] & m);
  endtask

  task automatic do_cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    clear = 1'b0; read_en = 1'b0; write_en = 1'b0; wmask = '0;
  endtask

  initial begin
    int          cnt0, cnt1, nz;
    logic [63:0] fwd_exp;

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 1024; a++) begin mmem[k][a] = '0; mknown[k][a] = '0; end

    rst_n = 1'b0; clear = 1'b0; read_en = 1'b0; addr_r = '0;
    write_en = 1'b0; addr_w = '0; wmask = '0; data_in = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;

`ifdef RAM_REG_MASK_FWD_EN
    fwd_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    fwd_exp = 64'h0;
`endif
    tv[0]  = mk(0, 0,    1, 3,    8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 0, 64'h0);
    tv[1]  = mk(1, 3,    0, 0,    8'h00, 64'h0,                   1, 64'hA5A5_A5A5_A5A5_A5A5);
    tv[2]  = mk(0, 0,    1, 3,    8'h0F, 64'h1122_3344_5566_7788, 0, 64'hA5A5_A5A5_A5A5_A5A5);
    tv[3]  = mk(1, 3,    0, 0,    8'h00, 64'h0,                   1, 64'hA5A5_A5A5_5566_7788);
    tv[4]  = mk(0, 0,    1, 7,    8'hFF, 64'h0,                   0, 64'hA5A5_A5A5_5566_7788);
    tv[5]  = mk(1, 7,    1, 7,    8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, fwd_exp);
    tv[6]  = mk(1, 7,    0, 0,    8'h00, 64'h0,                   1, 64'hFFFF_FFFF_FFFF_FFFF);
    tv[7]  = mk(0, 0,    1, 1010, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    tv[8]  = mk(1, 1010, 0, 0,    8'h00, 64'h0,                   1, 64'hDEAD_BEEF_CAFE_F00D);
    tv[9]  = mk(0, 0,    1, 999,  8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'hDEAD_BEEF_CAFE_F00D);
    tv[10] = mk(1, 999,  0, 0,    8'h00, 64'h0,                   1, 64'h0123_4567_89AB_CDEF);
    tv[11] = mk(0, 0,    1, 900,  8'hFF, 64'h9009_9009_9009_9009, 0, 64'h0123_4567_89AB_CDEF);
    tv[12] = mk(0, 0,    1, 3,    8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0123_4567_89AB_CDEF);
    tv[13] = mk(1, 3,    0, 0,    8'h00, 64'h0,                   1, 64'hA5A5_A5A5_5566_7788);

    for (int i = 0; i < 14; i++) begin
      clear = tv[i].clr; read_en = tv[i].re; addr_r = tv[i].ar;
      write_en = tv[i].we; addr_w = tv[i].aw; wmask = tv[i].wm; data_in = tv[i].din;
      do_cycle();
      chk($sformatf("tbl%0d_vld", i), 64'(d0_vld), 64'(tv[i].ev));
      chk($sformatf("tbl%0d_data", i), d0_data, tv[i].ed);
    end
    idle_in();

    // Out-of-range read on the 1000-deep, 2-cycle instance.
    read_en = 1'b1; addr_r = 10'd1010; do_cycle();
    read_en = 1'b0; do_cycle();
    chk("oor_vld", 64'(d1_vld), 64'h1);
    chk("oor_data", d1_data, 64'h0);
    read_en = 1'b1; addr_r = 10'd999; do_cycle();
    read_en = 1'b0; do_cycle();
    chk("d1_addr999", d1_data, 64'h0123_4567_89AB_CDEF);

    // Full clear: busy width, ignored re-clear, dropped mid-clear write.
    clear = 1'b1; do_cycle(); clear = 1'b0;
    cnt0 = int'(d0_busy); cnt1 = int'(d1_busy);
    for (int i = 1; i < 1100; i++) begin
      idle_in();
      if (i == 300) clear = 1'b1;
      if (i == 500) begin
        write_en = 1'b1; addr_w = 10'd5; wmask = 8'hFF; data_in = 64'h5555_5555_5555_5555;
        read_en = 1'b1; addr_r = 10'd5;
      end
      do_cycle();
      cnt0 += int'(d0_busy); cnt1 += int'(d1_busy);
    end
    idle_in();
    chk("busy_cycles_d0", 64'(cnt0), 64'd1024);
    chk("busy_cycles_d1", 64'(cnt1), 64'd1000);
    nz = 0;
    for (int a = 0; a < 1024; a++) begin
      read_en = 1'b1; addr_r = 10'(a); do_cycle();
      if (d0_vld && d0_data != 64'h0) nz++;
    end
    idle_in();
    chk("sweep_nonzero", 64'(nz), 64'h0);

    // Reset in the middle of a clear.
    write_en = 1'b1; wmask = 8'hFF;
    addr_w = 10'd50;  data_in = 64'h5050_5050_5050_5050; do_cycle();
    addr_w = 10'd900; data_in = 64'h9009_9009_9009_9009; do_cycle();
    idle_in();
    clear = 1'b1; do_cycle(); clear = 1'b0;
    for (int i = 0; i < 100; i++) do_cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 64'(d0_busy), 64'h0);
    chk("rst_data", d0_data, 64'h0);
    check_all();
    #2 rst_n = 1'b1;
    read_en = 1'b1; addr_r = 10'd50; do_cycle();
    chk("after_rst_a50", d0_data, 64'h0);
    addr_r = 10'd900; do_cycle();
    chk("after_rst_a900", d0_data, 64'h9009_9009_9009_9009);
    idle_in(); do_cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      clear    = (($urandom % 1000) == 0);
      read_en  = $urandom % 2;
      write_en = $urandom % 2;
      addr_r   = (($urandom % 8) == 0) ? 10'(990 + $urandom % 34) : 10'($urandom % 16);
      addr_w   = (($urandom % 8) == 0) ? 10'(990 + $urandom % 34) : 10'($urandom % 16);
      if (($urandom % 4) == 0) addr_w = addr_r;
      wmask    = 8'($urandom);
      data_in  = {$urandom, $urandom};
      do_cycle();
    end
    idle_in();
    do_cycle();
    do_cycle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
